codec_arbiter: RTL and testbench

Shares one encode/decode core (IDLE/ENCODE/DECODE mode interface, N-bit codeword, K-bit message) between two requesters. It arbitrates round-robin, drives the core's mode and data inputs, waits for the core's completion pulse, and returns the result to the requester that was granted. It sits directly in front of the codec core inside the system top, replacing direct mode/data_in driving by a single host.

---
 rtl/codec_arbiter_if.sv | 29 ++
 rtl/codec_arbiter.sv | 143 ++++++++++++++
 tb/tb_codec_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_arbiter_if.sv
// Bundle between the codec arbiter, its two requesters and the shared codec core.
// master = arbiter side, slave = requester/core environment side.
interface codec_arbiter_if #(
  parameter int N = 64
);
  logic [1:0]     req_valid;
  logic [1:0]     req_op;
  logic [2*N-1:0] req_data;
  logic [1:0]     req_ready;
  logic [1:0]     resp_valid;
  logic [N-1:0]   resp_data;
  logic           resp_err;
  logic [1:0]     resp_ready;
  logic [2:0]     core_mode;
  logic [N-1:0]   core_data_in;
  logic [N-1:0]   core_data_out;
  logic           core_done;
  logic           busy;

  modport master (
    input  req_valid, req_op, req_data, resp_ready, core_data_out, core_done,
    output req_ready, resp_valid, resp_data, resp_err, core_mode, core_data_in, busy
  );

  modport slave (
    output req_valid, req_op, req_data, resp_ready, core_data_out, core_done,
    input  req_ready, resp_valid, resp_data, resp_err, core_mode, core_data_in, busy
  );
endinterface

// File: rtl/codec_arbiter.sv
// Round-robin arbiter sharing one encode/decode core between two requesters.
// Optional macro CODEC_TIMEOUT_EN aborts an operation after TIMEOUT WAIT cycles with resp_err.
module codec_arbiter #(
  parameter int N       = 64,
  parameter int K       = 40,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  codec_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] MODE_IDLE = 3'b000;
  localparam logic [2:0] MODE_ENC  = 3'b001;
  localparam logic [2:0] MODE_DEC  = 3'b010;

  state_e       state_q, state_d;
  logic         rr_ptr_q, rr_ptr_d;
  logic         gnt_q, gnt_d;
  logic         op_q, op_d;
  logic [N-1:0] payload_q, payload_d;
  logic [N-1:0] resp_data_q, resp_data_d;
  logic         resp_err_q, resp_err_d;

  logic         gnt_sel;
  logic [N-1:0] req_word;
  logic [1:0]   req_ready_c;
  logic         timeout_hit;

  // Single valid requester wins outright; a tie goes to rr_ptr.
  always_comb begin
    gnt_sel  = (bus.req_valid == 2'b11) ? rr_ptr_q : bus.req_valid[1];
    req_word = gnt_sel ? bus.req_data[2*N-1:N] : bus.req_data[N-1:0];
  end

`ifdef CODEC_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    payload_d   = payload_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    req_ready_c = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c[gnt_sel] = 1'b1;
          gnt_d                = gnt_sel;
          op_d                 = bus.req_op[gnt_sel];
          payload_d            = bus.req_op[gnt_sel] ? req_word
                                                     : {{(N-K){1'b0}}, req_word[K-1:0]};
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse coinciding with the timeout still delivers the result.
        if (bus.core_done) begin
          resp_data_d = op_q ? {{(N-K){1'b0}}, bus.core_data_out[K-1:0]} : bus.core_data_out;
          resp_err_d  = 1'b0;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready[gnt_q]) begin
          rr_ptr_d = ~gnt_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      gnt_q       <= 1'b0;
      op_q        <= 1'b0;
      payload_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      payload_q   <= payload_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Mode follows the state, so leaving WAIT (or reset) drops the core to IDLE on the same edge.
  assign bus.core_mode    = ((state_q == S_ISSUE) || (state_q == S_WAIT))
                            ? (op_q ? MODE_DEC : MODE_ENC) : MODE_IDLE;
  assign bus.core_data_in = payload_q;
  assign bus.req_ready    = req_ready_c;
  assign bus.resp_valid   = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_codec_arbiter.sv
// Directed bench for codec_arbiter with a behavioural codec core model.
// Define CODEC_TIMEOUT_EN to also exercise the timeout abort path (TIMEOUT=16).
module tb_codec_arbiter;
  localparam int N = 64;
  localparam int K = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  codec_arbiter_if #(.N(N)) bus();

  codec_arbiter #(.N(N), .K(K), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Core model: done pulses core_lat edges after the core leaves IDLE.
  int core_cnt = 0;
  int core_lat = 3;
  bit core_en  = 1'b1;

  function automatic logic [63:0] core_fn(input logic [2:0] mode, input logic [63:0] din);
    if (mode == 3'b001) return {din[23:0] ^ 24'h5A5A5A, din[39:0]};
    return {~din[63:40], din[39:0]};
  endfunction

  always begin
    @(posedge clk);
    #4;
    if (bus.core_mode != 3'b000) begin
      core_cnt++;
      if (core_en && core_cnt == core_lat) begin
        bus.core_done     = 1'b1;
        bus.core_data_out = core_fn(bus.core_mode, bus.core_data_in);
      end else begin
        bus.core_done = 1'b0;
      end
    end else begin
      core_cnt      = 0;
      bus.core_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int edges);
    edges = 0;
    while (bus.resp_valid == 2'b00 && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    bit seen;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.req_ready, bus.resp_valid, bus.resp_err, bus.core_mode} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {bus.busy, bus.req_ready, bus.resp_valid, bus.resp_err, bus.core_mode});
    end
    n_checks++;
    if (bus.resp_data !== 64'h0 || bus.core_data_in !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: resp_data=%h core_data_in=%h required 0", bus.resp_data, bus.core_data_in);
    end
    // Start an encode and reset it while the core is still busy in WAIT.
    core_en = 1'b0;
    bus.req_valid = 2'b01; bus.req_op = 2'b00; bus.req_data = {64'h0, 64'h0000_00AB_CDEF_0123};
    tick();
    bus.req_valid = 2'b00;
    tick();
    n_checks++;
    if (bus.core_mode !== 3'b001 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prewait: core_mode=%b busy=%b required 001/1", bus.core_mode, bus.busy);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.core_mode !== 3'b000 || bus.busy !== 1'b0 || bus.core_data_in !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_midwait: core_mode=%b busy=%b core_data_in=%h required 000/0/0",
               bus.core_mode, bus.busy, bus.core_data_in);
    end
    tick(); tick();
    rst = 1'b0;
    core_en = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.resp_valid !== 2'b00 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_no_resp: activity after abandoned op, got 1 required 0");
    end
  endtask

  task automatic test_contention();
    int edges;
    bit g;
    logic [63:0] exp_cw;
    bus.req_valid  = 2'b11;
    bus.req_op     = 2'b00;
    bus.req_data   = {64'h0000_0022_2222_2222, 64'h0000_0011_1111_1111};
    bus.resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      edges = 0;
      #1;
      while (bus.req_ready == 2'b00 && edges < 20) begin
        tick(); #1; edges++;
      end
      n_checks++;
      if (bus.req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL contention_grant%0d: req_ready=%b required %b", i, bus.req_ready,
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      g = bus.req_ready[1];
      exp_cw = g ? 64'h7878_7822_2222_2222 : 64'h4B4B_4B11_1111_1111;
      tick();
      wait_resp(edges);
      n_checks++;
      if (bus.resp_valid !== (g ? 2'b10 : 2'b01) || bus.resp_data !== exp_cw) begin
        n_fail++;
        $display("FAIL contention_resp%0d: resp_valid=%b data=%h required %b %h", i,
                 bus.resp_valid, bus.resp_data, g ? 2'b10 : 2'b01, exp_cw);
      end
      tick();
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    tick();
  endtask

  task automatic test_encode();
    int edges;
    bus.req_valid = 2'b01; bus.req_op = 2'b00;
    bus.req_data  = {64'h0, 64'hFFFF_FFDD_5486_AA91};
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL enc_ready: req_ready=%b required 01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00 || bus.core_mode !== 3'b001 || bus.core_data_in !== 64'h0000_00DD_5486_AA91) begin
      n_fail++;
      $display("FAIL enc_issue: req_ready=%b core_mode=%b core_data_in=%h required 00/001/00000000dd5486aa91",
               bus.req_ready, bus.core_mode, bus.core_data_in);
    end
    wait_resp(edges);
    // accept edge -> ISSUE -> two WAIT cycles -> done edge
    n_checks++;
    if (edges != 3) begin
      n_fail++;
      $display("FAIL enc_latency: edges=%0d required 3", edges);
    end
    n_checks++;
    if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'hDCF0_CBDD_5486_AA91 || bus.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_resp: valid=%b data=%h err=%b required 01 dcf0cbdd5486aa91 0",
               bus.resp_valid, bus.resp_data, bus.resp_err);
    end
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    n_checks++;
    if (bus.resp_valid !== 2'b00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_release: valid=%b busy=%b required 00/0", bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_decode();
    int edges;
    bus.req_valid = 2'b10; bus.req_op = 2'b10;
    bus.req_data  = {64'h23F0_CBDD_5486_AA91, 64'h0};
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL dec_ready: req_ready=%b required 10", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.core_mode !== 3'b010 || bus.core_data_in !== 64'h23F0_CBDD_5486_AA91) begin
      n_fail++;
      $display("FAIL dec_issue: core_mode=%b core_data_in=%h required 010 23f0cbdd5486aa91",
               bus.core_mode, bus.core_data_in);
    end
    wait_resp(edges);
    n_checks++;
    if (edges != 3 || bus.resp_valid !== 2'b10 || bus.resp_data !== 64'h0000_00DD_5486_AA91 || bus.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_resp: edges=%0d valid=%b data=%h err=%b required 3 10 000000dd5486aa91 0",
               edges, bus.resp_valid, bus.resp_data, bus.resp_err);
    end
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    int edges;
    bus.req_valid = 2'b11; bus.req_op = 2'b00;
    bus.req_data  = {64'h0000_0055_5555_5555, 64'h0000_0001_2345_6789};
    tick();
    wait_resp(edges);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'h1F3D_D301_2345_6789 || bus.req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h req_ready=%b required 01 1f3dd30123456789 00",
                 i, bus.resp_valid, bus.resp_data, bus.req_ready);
      end
      tick();
    end
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b req_ready=%b required 00 10", bus.resp_valid, bus.req_ready);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

`ifdef CODEC_TIMEOUT_EN
  task automatic test_timeout();
    int edges;
    core_en = 1'b0;
    bus.req_valid = 2'b01; bus.req_op = 2'b00;
    bus.req_data  = {64'h0, 64'h0000_00DD_5486_AA91};
    tick();
    bus.req_valid = 2'b00;
    wait_resp(edges);
    // one ISSUE edge plus 16 WAIT cycles
    n_checks++;
    if (edges != 17 || bus.resp_valid !== 2'b01 || bus.resp_err !== 1'b1 || bus.resp_data !== 64'h0 || bus.core_mode !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_abort: edges=%0d valid=%b err=%b data=%h mode=%b required 17 01 1 0 000",
               edges, bus.resp_valid, bus.resp_err, bus.resp_data, bus.core_mode);
    end
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    core_en  = 1'b1;
    core_lat = 17;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    wait_resp(edges);
    n_checks++;
    if (edges != 17 || bus.resp_err !== 1'b0 || bus.resp_data !== 64'hDCF0_CBDD_5486_AA91) begin
      n_fail++;
      $display("FAIL timeout_race: edges=%0d err=%b data=%h required 17 0 dcf0cbdd5486aa91",
               edges, bus.resp_err, bus.resp_data);
    end
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    core_lat = 3;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid     = 2'b00;
    bus.req_op        = 2'b00;
    bus.req_data      = '0;
    bus.resp_ready    = 2'b00;
    bus.core_data_out = '0;
    bus.core_done     = 1'b0;
    test_reset();
    test_contention();
    test_encode();
    test_decode();
    test_backpressure();
`ifdef CODEC_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
